// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux block and its lane slices.
package stream_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  localparam int DROP_CNT_W      = 16;
  localparam int DEMUX_N_DEFAULT = 16;
  localparam int DEMUX_W_DEFAULT = 4;

endpackage

// File: rtl/demux_lane.sv
// One-entry output register slice for a single demux lane.
// A load always wins over a drain, so a simultaneous drain+load keeps the
// slot FULL with the new word.
module demux_lane
  import stream_demux_pkg::*;
#(
  parameter int W = DEMUX_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         drain,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  lane_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // Next-state and data-reload logic for the EMPTY/FULL slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = ld_data;
    end else if ((state_q == FULL) && drain) begin
      state_d = EMPTY;
    end
  end

  // State and data registers; data is held (not cleared) when the slot drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: sequential 1-to-N demultiplexer onto a packed N*W lane bus.
// Words addressed beyond the last lane are accepted, discarded and counted.
// Optional build macro STREAM_DEMUX_AUTO_SEL_EN: in_sel is ignored and an
// internal round-robin pointer (exposed on cur_sel) picks the lane instead.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N     = DEMUX_N_DEFAULT,
  parameter  int W     = DEMUX_W_DEFAULT,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*W-1:0]        out_data,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic                  drop_pulse,
`ifdef STREAM_DEMUX_AUTO_SEL_EN
  output logic [SEL_W-1:0]      cur_sel,
`endif
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Lane vectors padded to the full select range so any select value indexes safely.
  localparam int NP = 1 << SEL_W;

  logic [NP-1:0]         full_pad;
  logic [NP-1:0]         rdy_pad;
  logic [NP-1:0]         load_pad;
  logic [N-1:0]          lane_load;
  logic [SEL_W-1:0]      sel_eff;
  logic                  sel_oob;
  logic                  accept;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef STREAM_DEMUX_AUTO_SEL_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             sel_unused;

  assign sel_unused = ^in_sel;

  // Round-robin pointer advances on every accept and wraps after lane N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + SEL_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign cur_sel = ptr_q;
`endif

  // Select decode, in_ready mux, lane load strobes and drop counter next state.
  always_comb begin
`ifdef STREAM_DEMUX_AUTO_SEL_EN
    sel_eff = ptr_q;
    sel_oob = 1'b0;
`else
    sel_eff = in_sel;
    sel_oob = (32'(in_sel) >= 32'(N));
`endif
    full_pad     = NP'(out_valid);
    rdy_pad      = NP'(out_ready);
    in_ready     = sel_oob | ~full_pad[sel_eff] | rdy_pad[sel_eff];
    accept       = in_valid & in_ready;
    load_pad     = NP'(accept & ~sel_oob) << sel_eff;
    lane_load    = load_pad[N-1:0];
    drop_pulse_d = accept & sel_oob;
    drop_cnt_d   = drop_cnt_q;
    if (drop_pulse_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Drop pulse and saturating drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    demux_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lane_load[i]),
      .ld_data  (in_data),
      .drain    (out_ready[i]),
      .out_data (out_data[i*W +: W]),
      .out_valid(out_valid[i])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 16-lane and a 12-lane instance checked every cycle
// against a per-lane slot/count model, with directed steps then random traffic.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_data [2];
  logic [3:0]  i_sel  [2];
  logic        i_vld  [2];
  logic [15:0] ordy   [2];
  logic        o_rdy  [2];
  logic        o_pulse[2];
  logic [15:0] o_cnt  [2];
  logic [3:0]  o_cur  [2];
  logic [63:0] a_out_data;
  logic [15:0] a_out_valid;
  logic [47:0] b_out_data;
  logic [11:0] b_out_valid;

  int checks = 0;
  int errors = 0;

  bit         m_full [2][16];
  logic [3:0] m_data [2][16];
  int         m_cnt  [2];
  bit         m_pulse[2];
  int         m_ptr  [2];
  bit         last_acc[2];

  always #5 clk = ~clk;

  stream_demux #(.N(16), .W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(i_data[0]), .in_sel(i_sel[0]),
    .in_valid(i_vld[0]), .in_ready(o_rdy[0]), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(ordy[0]), .drop_pulse(o_pulse[0]),
`ifdef STREAM_DEMUX_AUTO_SEL_EN
    .cur_sel(o_cur[0]),
`endif
    .drop_cnt(o_cnt[0])
  );

  stream_demux #(.N(12), .W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(i_data[1]), .in_sel(i_sel[1]),
    .in_valid(i_vld[1]), .in_ready(o_rdy[1]), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(ordy[1][11:0]), .drop_pulse(o_pulse[1]),
`ifdef STREAM_DEMUX_AUTO_SEL_EN
    .cur_sel(o_cur[1]),
`endif
    .drop_cnt(o_cnt[1])
  );

`ifndef STREAM_DEMUX_AUTO_SEL_EN
  assign o_cur[0] = 4'd0;
  assign o_cur[1] = 4'd0;
`endif

  function automatic int nl(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        m_full[d][i] = 1'b0;
        m_data[d][i] = 4'd0;
      end
      m_cnt[d]    = 0;
      m_pulse[d]  = 1'b0;
      m_ptr[d]    = 0;
      last_acc[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] ev, ed, ov, od;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      ed = '0;
      for (int i = 0; i < nl(d); i++) begin
        ev[i]       = m_full[d][i];
        ed[i*4 +: 4] = m_data[d][i];
      end
      ov = (d == 0) ? 64'(a_out_valid) : 64'(b_out_valid);
      od = (d == 0) ? a_out_data : 64'(b_out_data);
      chk("out_valid", d, ov, ev);
      chk("out_data", d, od, ed);
      chk("drop_pulse", d, 64'(o_pulse[d]), 64'(m_pulse[d]));
      chk("drop_cnt", d, 64'(o_cnt[d]), 64'(m_cnt[d]));
`ifdef STREAM_DEMUX_AUTO_SEL_EN
      chk("cur_sel", d, 64'(o_cur[d]), 64'(m_ptr[d]));
`endif
    end
  endtask

  // One clock cycle: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit acc[2];
    int s[2];
    bit er;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
`ifdef STREAM_DEMUX_AUTO_SEL_EN
      s[d] = m_ptr[d];
`else
      s[d] = int'(i_sel[d]);
`endif
      er = (s[d] >= nl(d)) || !m_full[d][s[d]] || ordy[d][s[d]];
      chk("in_ready", d, 64'(o_rdy[d]), 64'(er));
      acc[d] = i_vld[d] && er;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nl(d); i++) begin
        if (m_full[d][i] && ordy[d][i]) m_full[d][i] = 1'b0;
        if (acc[d] && s[d] == i) begin
          m_full[d][i] = 1'b1;
          m_data[d][i] = i_data[d];
        end
      end
      m_pulse[d] = acc[d] && (s[d] >= nl(d));
      if (m_pulse[d] && m_cnt[d] < 65535) m_cnt[d]++;
      if (acc[d]) m_ptr[d] = (m_ptr[d] + 1) % nl(d);
      last_acc[d] = acc[d];
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      i_vld[d]  = 1'b0;
      i_sel[d]  = 4'd0;
      i_data[d] = 4'd0;
      ordy[d]   = 16'hFFFF;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef STREAM_DEMUX_AUTO_SEL_EN
    // Twenty words round-robin across the 16-lane instance.
    for (int j = 0; j < 20; j++) begin
      i_vld[0]  = 1'b1;
      i_data[0] = 4'(j);
      i_sel[0]  = 4'($urandom_range(0, 15));
      step();
    end
    i_vld[0] = 1'b0;
    step();
    chk("cur_sel_end", 0, 64'(o_cur[0]), 64'd4);
`else
    // Sweep: lane i gets value i, consumers always ready.
    for (int i = 0; i < 16; i++) begin
      i_vld[0]  = 1'b1;
      i_sel[0]  = 4'(i);
      i_data[0] = 4'(i);
      step();
    end
    i_vld[0] = 1'b0;
    step();
`endif

    // Backpressure on lane 5: A held, B stalled, then drain+reload together.
    ordy[0][5] = 1'b0;
    i_vld[0] = 1'b1; i_sel[0] = 4'd5; i_data[0] = 4'hA;
    step();
    i_data[0] = 4'hB;
    step();
    step();
    ordy[0][5] = 1'b1;
    step();
    i_vld[0] = 1'b0;
    step();
    step();

    // Concurrency: lane 2 stalled and full, lane 3 still accepts immediately.
    ordy[0][2] = 1'b0;
    i_vld[0] = 1'b1; i_sel[0] = 4'd2; i_data[0] = 4'h7;
    step();
    i_sel[0] = 4'd3; i_data[0] = 4'h9;
    step();
    i_vld[0] = 1'b0;
    step();
    ordy[0][2] = 1'b1;
    step();

    // Drop path on the 12-lane instance, then saturation from a preloaded count.
    i_vld[1] = 1'b1; i_sel[1] = 4'd13; i_data[1] = 4'h5;
    repeat (3) step();
    i_vld[1] = 1'b0;
    step();
`ifndef STREAM_DEMUX_AUTO_SEL_EN
    chk("drop_cnt_three", 1, 64'(o_cnt[1]), 64'd3);
    force u_b.drop_cnt_q = 16'hFFFE;
    #1;
    release u_b.drop_cnt_q;
    m_cnt[1] = 16'hFFFE;
    i_vld[1] = 1'b1;
    repeat (3) step();
    i_vld[1] = 1'b0;
    step();
    chk("drop_cnt_sat", 1, 64'(o_cnt[1]), 64'hFFFF);
`endif

    // Random traffic on both instances, honouring the hold-while-stalled rule.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (!(i_vld[d] && !last_acc[d])) begin
          i_vld[d]  = 1'($urandom_range(0, 1));
          i_sel[d]  = 4'($urandom_range(0, 15));
          i_data[d] = 4'($urandom);
        end
        ordy[d] = 16'($urandom);
      end
      step();
    end

    // Reset mid-stream with lanes 0, 7 and 15 holding words.
    idle_inputs();
    step();
    ordy[0] = 16'h0000;
    i_vld[0] = 1'b1;
    i_sel[0] = 4'd0;  i_data[0] = 4'h1; step();
    i_sel[0] = 4'd7;  i_data[0] = 4'h2; step();
    i_sel[0] = 4'd15; i_data[0] = 4'h3; step();
    i_vld[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 16'hFFFF;
    i_vld[0] = 1'b1; i_sel[0] = 4'd7; i_data[0] = 4'hC;
    step();
    i_vld[0] = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
